mm_arbiter: RTL and testbench

Two-port arbiter that shares the single line-wide main memory port (256-bit line data, 32-byte lines) between two L1 cache controllers, e.g. I-side and D-side. It sits between the caches' `mm_*` request ports and `mainmemory`. It serializes accesses one line at a time with round-robin fairness. It sequences the write-throughput hold time, because memory gives no write acknowledge.

---
 rtl/mm_arbiter.sv | 157 +++++++++++++++
 tb/tb_mm_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mm_arbiter.sv
// Round-robin arbiter sharing one line-wide main memory port between two L1 controllers.
// Latency: strobe one cycle after grant; read/write complete pulse then one RESP cycle; requesters wait on level requests.
module mm_arbiter #(
    parameter int unsigned WRITE_TPUT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  rq0_a,
    input  logic         rq0_read,
    input  logic         rq0_write,
    input  logic [255:0] rq0_wd,
    output logic [255:0] rq0_rd,
    output logic         rq0_rd_valid,
    output logic         rq0_wr_done,
    input  logic [31:0]  rq1_a,
    input  logic         rq1_read,
    input  logic         rq1_write,
    input  logic [255:0] rq1_wd,
    output logic [255:0] rq1_rd,
    output logic         rq1_rd_valid,
    output logic         rq1_wr_done,
    output logic [31:0]  mm_a,
    output logic         mm_read,
    output logic         mm_write,
    output logic [255:0] mm_wd,
    input  logic [255:0] mm_rd,
    input  logic         mm_readdata_valid,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t       state_q;
    logic         pri_q;
    logic         gnt_q;
    logic [7:0]   cnt_q;

    logic         req0;
    logic         req1;
    logic         gnt_vld;
    logic         gnt_d;
    logic         pri_d;
    logic         g_read;
    logic         g_write;
    logic [31:0]  g_a;
    logic [255:0] g_wd;

    // Line offset bits are not part of the memory address.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{rq0_a[4:0], rq1_a[4:0]};

    always_comb begin
        req0    = rq0_read | rq0_write;
        req1    = rq1_read | rq1_write;
        gnt_vld = req0 | req1;
        gnt_d   = 1'b0;
        pri_d   = pri_q;
        if (req0 && req1) begin
            gnt_d = pri_q;
            pri_d = ~pri_q;
        end else if (req1) begin
            gnt_d = 1'b1;
        end
        g_read  = gnt_d ? rq1_read  : rq0_read;
        g_write = gnt_d ? rq1_write : rq0_write;
        g_a     = gnt_d ? rq1_a     : rq0_a;
        g_wd    = gnt_d ? rq1_wd    : rq0_wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pri_q        <= 1'b0;
            gnt_q        <= 1'b0;
            cnt_q        <= 8'd0;
            mm_a         <= 32'd0;
            mm_read      <= 1'b0;
            mm_write     <= 1'b0;
            mm_wd        <= 256'd0;
            rq0_rd       <= 256'd0;
            rq1_rd       <= 256'd0;
            rq0_rd_valid <= 1'b0;
            rq1_rd_valid <= 1'b0;
            rq0_wr_done  <= 1'b0;
            rq1_wr_done  <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rq0_rd_valid <= 1'b0;
            rq1_rd_valid <= 1'b0;
            rq0_wr_done  <= 1'b0;
            rq1_wr_done  <= 1'b0;
            if (mm_readdata_valid && state_q != RD) begin
                err <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        gnt_q <= gnt_d;
                        pri_q <= pri_d;
                        mm_a  <= {g_a[31:5], 5'b0};
                        mm_wd <= g_wd;
                        cnt_q <= 8'd0;
                        busy  <= 1'b1;
                        if (g_write) begin
                            state_q  <= WR;
                            mm_write <= 1'b1;
                            if (g_read) begin
                                err <= 1'b1;
                            end
                        end else begin
                            state_q <= RD;
                            mm_read <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (mm_readdata_valid) begin
                        mm_read <= 1'b0;
                        state_q <= RESP;
                        if (gnt_q) begin
                            rq1_rd       <= mm_rd;
                            rq1_rd_valid <= 1'b1;
                        end else begin
                            rq0_rd       <= mm_rd;
                            rq0_rd_valid <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // Memory has no write acknowledge: completion is purely time based.
                    if (cnt_q == 8'(WRITE_TPUT - 1)) begin
                        mm_write <= 1'b0;
                        state_q  <= RESP;
                        if (gnt_q) begin
                            rq1_wr_done <= 1'b1;
                        end else begin
                            rq0_wr_done <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter with a small fixed-latency memory model.
module tb_mm_arbiter;

    localparam int READ_LAT = 4;

    logic         clk;
    logic         reset;
    logic [31:0]  rq0_a, rq1_a;
    logic         rq0_read, rq0_write, rq1_read, rq1_write;
    logic [255:0] rq0_wd, rq1_wd;
    logic [255:0] rq0_rd, rq1_rd;
    logic         rq0_rd_valid, rq1_rd_valid, rq0_wr_done, rq1_wr_done;
    logic [31:0]  mm_a;
    logic         mm_read, mm_write;
    logic [255:0] mm_wd, mm_rd;
    logic         mm_readdata_valid;
    logic         busy, err;

    int n_tot = 0;
    int n_pass = 0;
    int rd_wait = 0;
    int overlap = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int v0 = 0;
    int v1 = 0;
    int n0, n1;
    int seq[$];
    logic mem_en = 1'b0;
    logic [255:0] line = '0;

    mm_arbiter #(.WRITE_TPUT(4)) dut (
        .clk(clk), .reset(reset),
        .rq0_a(rq0_a), .rq0_read(rq0_read), .rq0_write(rq0_write), .rq0_wd(rq0_wd),
        .rq0_rd(rq0_rd), .rq0_rd_valid(rq0_rd_valid), .rq0_wr_done(rq0_wr_done),
        .rq1_a(rq1_a), .rq1_read(rq1_read), .rq1_write(rq1_write), .rq1_wd(rq1_wd),
        .rq1_rd(rq1_rd), .rq1_rd_valid(rq1_rd_valid), .rq1_wr_done(rq1_wr_done),
        .mm_a(mm_a), .mm_read(mm_read), .mm_write(mm_write), .mm_wd(mm_wd),
        .mm_rd(mm_rd), .mm_readdata_valid(mm_readdata_valid),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: memory model, observation counters, requesters drop on completion.
    task automatic cyc();
        @(negedge clk);
        if (mm_readdata_valid) begin
            mm_readdata_valid = 1'b0;
        end else if (mem_en && mm_read) begin
            rd_wait++;
            if (rd_wait == READ_LAT + 1) begin
                mm_readdata_valid = 1'b1;
                mm_rd = line;
                rd_wait = 0;
            end
        end else begin
            rd_wait = 0;
        end
        if (mm_read && mm_write) overlap++;
        if (mm_write) wr_cycles++;
        if (mm_read) rd_cycles++;
        if (rq0_rd_valid) begin v0++; seq.push_back(0); end
        if (rq1_rd_valid) begin v1++; seq.push_back(1); end
        if (rq0_rd_valid || rq0_wr_done) begin rq0_read = 1'b0; rq0_write = 1'b0; end
        if (rq1_rd_valid || rq1_wr_done) begin rq1_read = 1'b0; rq1_write = 1'b0; end
    endtask

    initial begin
        reset = 1'b1;
        rq0_a = '0; rq1_a = '0; rq0_read = 0; rq0_write = 0; rq1_read = 0; rq1_write = 0;
        rq0_wd = '0; rq1_wd = '0; mm_rd = '0; mm_readdata_valid = 1'b0;
        cyc();
        cyc();
        chk("rst_mm_read", mm_read, 0);
        chk("rst_mm_write", mm_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_rq0_rd", rq0_rd, 0);
        chk("rst_rq1_valid", rq1_rd_valid, 0);
        reset = 1'b0;
        cyc();

        // Single read from rq0
        mem_en = 1'b1;
        line = {32{8'hA5}};
        v0 = 0; v1 = 0;
        rq0_a = 32'h0000_1234;
        rq0_read = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) begin
                chk("rd_mm_read", mm_read, 1);
                chk("rd_mm_a", mm_a, 32'h0000_1220);
                chk("rd_busy", busy, 1);
            end
            if (c >= 2 && c <= 5) chk($sformatf("rd_early_valid_c%0d", c), rq0_rd_valid, 0);
            if (c == 6) begin
                chk("rd_valid", rq0_rd_valid, 1);
                chk("rd_data", rq0_rd, {32{8'hA5}});
                chk("rd_strobe_resp", mm_read, 0);
            end
            if (c == 7) begin
                chk("rd_valid_drop", rq0_rd_valid, 0);
                chk("rd_idle", busy, 0);
            end
        end
        chk("rd_pulse_count", 256'(v0), 1);
        chk("rd_rq1_quiet", 256'(v1), 0);
        chk("rd_rq1_data", rq1_rd, 0);

        // Single write from rq1
        wr_cycles = 0;
        rq1_a = 32'h0000_0040;
        rq1_wd = {8{32'h1357_9BDF}};
        rq1_write = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) begin
                chk("wr_mm_wd", mm_wd, {8{32'h1357_9BDF}});
                chk("wr_mm_a", mm_a, 32'h0000_0040);
            end
            if (c == 4) chk("wr_done_early", rq1_wr_done, 0);
            if (c == 5) begin
                chk("wr_done", rq1_wr_done, 1);
                chk("wr_strobe_resp", mm_write, 0);
                chk("wr_rq0_done", rq0_wr_done, 0);
            end
            if (c == 6) chk("wr_idle", busy, 0);
        end
        chk("wr_cycles", 256'(wr_cycles), 4);

        // Both requesters read repeatedly: grants must alternate
        line = {32{8'h3C}};
        seq.delete();
        overlap = 0;
        rq0_a = 32'h0000_2000; rq1_a = 32'h0000_3000;
        rq0_read = 1'b1; rq1_read = 1'b1;
        n0 = 1; n1 = 1;
        for (int c = 0; c < 200 && seq.size() < 4; c++) begin
            cyc();
            if (!rq0_read && !rq0_rd_valid && n0 < 2) begin rq0_read = 1'b1; n0++; end
            if (!rq1_read && !rq1_rd_valid && n1 < 2) begin rq1_read = 1'b1; n1++; end
        end
        chk("rr_completions", 256'(seq.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seq.size()) chk($sformatf("rr_order_%0d", i), 256'(seq[i]), 256'(i % 2));
        end
        cyc();
        cyc();
        chk("rr_overlap", 256'(overlap), 0);
        chk("rr_rq1_data", rq1_rd, {32{8'h3C}});

        // Back-to-back reads from rq0 alone
        v0 = 0;
        rq0_read = 1'b1;
        for (int c = 0; c < 30 && !rq0_rd_valid; c++) cyc();
        chk("b2b_first", rq0_rd_valid, 1);
        cyc();
        chk("b2b_idle_strobe", mm_read, 0);
        chk("b2b_idle_busy", busy, 0);
        rq0_read = 1'b1;
        cyc();
        chk("b2b_second_strobe", mm_read, 1);
        for (int c = 0; c < 30 && !rq0_rd_valid; c++) cyc();
        for (int c = 0; c < 5; c++) cyc();
        chk("b2b_pulse_count", 256'(v0), 2);

        // Reset in the middle of a read, then a late memory valid
        mem_en = 1'b0;
        v0 = 0;
        rq0_a = 32'h0000_0080;
        rq0_read = 1'b1;
        cyc();
        cyc();
        chk("rst_mid_in_rd", mm_read, 1);
        reset = 1'b1;
        rq0_read = 1'b0;
        cyc();
        chk("rst_mid_mm_read", mm_read, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rd_data", rq0_rd, 0);
        chk("rst_mid_mm_a", mm_a, 0);
        reset = 1'b0;
        mm_rd = {32{8'hEE}};
        mm_readdata_valid = 1'b1;
        cyc();
        chk("late_valid_err", err, 1);
        cyc();
        chk("late_no_rd_valid", 256'(v0), 0);
        chk("late_busy", busy, 0);
        reset = 1'b1;
        cyc();
        chk("rst_clears_err", err, 0);
        reset = 1'b0;
        cyc();

        // Read and write together: write wins, err sticks
        mem_en = 1'b1;
        rd_cycles = 0; wr_cycles = 0;
        rq0_a = 32'h0000_0100;
        rq0_wd = {4{64'h0123_4567_89AB_CDEF}};
        rq0_read = 1'b1; rq0_write = 1'b1;
        cyc();
        chk("perr_write_strobe", mm_write, 1);
        chk("perr_wd", mm_wd, {4{64'h0123_4567_89AB_CDEF}});
        for (int c = 0; c < 20 && !rq0_wr_done; c++) cyc();
        chk("perr_wr_done", rq0_wr_done, 1);
        for (int c = 0; c < 5; c++) cyc();
        chk("perr_err_sticky", err, 1);
        chk("perr_no_read", 256'(rd_cycles), 0);
        chk("perr_wr_cycles", 256'(wr_cycles), 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
